postfix_eval: RTL and testbench
===============================

POSTFIX_EVAL -- requirements
Module: postfix_eval

Interface
REQ-001 SHALL have parameter DATA_W, default 16: operand/result width in bits, two's complement.
REQ-002 SHALL have parameter DEPTH, default 8: operand stack entries (2..16).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  clock, all state on rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 NUMBER_IN  in  8  unsigned operand token.
REQ-007 NUMBER_STB  in  1  NUMBER_IN valid; held until NUMBER_ACK.
REQ-008 NUMBER_ACK  out  1  one-cycle pulse: number token consumed.
REQ-009 SIGN_IN  in  8  ASCII operator token.
REQ-010 SIGN_STB  in  1  SIGN_IN valid; held until SIGN_ACK.
REQ-011 SIGN_ACK  out  1  one-cycle pulse: operator token consumed.
REQ-012 END_STB  in  1  end of expression; held until END_ACK.
REQ-013 END_ACK  out  1  one-cycle pulse: end marker consumed.
REQ-014 RESULT  out  DATA_W  evaluated value (0 when ERR_CODE != 0).
REQ-015 ERR_CODE  out  3  0 ok, 1 underflow, 2 overflow, 3 divide by zero, 4 bad operator, 5 bad end.
REQ-016 RESULT_STB  out  1  RESULT/ERR_CODE valid; held until RESULT_ACK.
REQ-017 RESULT_ACK  in  1  consumer took result.
REQ-018 BUSY  out  1  high whenever FSM not in GET.

Function
REQ-019 FSM states SHALL be GET, EXEC, DONE; reset state GET.
REQ-020 In GET, priority SHALL be NUMBER_STB > SIGN_STB > END_STB; only one token accepted per cycle.
REQ-021 Token accepted at edge where strobe sampled high in GET; matching ACK high exactly the following cycle; FSM not in GET that cycle, so held strobe is not re-accepted.
REQ-022 Number: zero-extend to DATA_W, push; depth==DEPTH -> ERR_CODE 2, go DONE; else stay GET.
REQ-023 Operator: latch SIGN_IN, go EXEC; 43 '+', 45 '-', 42 '*', 47 '/' valid; any other -> ERR_CODE 4, go DONE.
REQ-024 EXEC (one cycle): depth<2 -> ERR_CODE 1, DONE; else pop b (top), a (next), push a op b, depth decrements by 1, return GET.
REQ-025 Arithmetic modulo 2^DATA_W: '+' and '-' wrap, '*' keeps low DATA_W bits of signed product, '/' signed truncating toward zero.
REQ-026 '/' with b==0 -> ERR_CODE 3, DONE, stack unchanged until cleared; most-negative / -1 yields most-negative (wrap).
REQ-027 End marker: depth==1 -> RESULT=top, ERR_CODE 0; else ERR_CODE 5, RESULT 0; go DONE.
REQ-028 DONE: RESULT_STB high; on RESULT_ACK sampled high: RESULT_STB low next cycle, stack depth cleared to 0, ERR_CODE 0, go GET.
REQ-029 On any error, tokens arriving before RESULT_ACK SHALL not be acknowledged.
REQ-030 Operator latency: accept edge to result-on-stack = 2 cycles; number = 1 cycle; minimum number throughput 1 token per 2 cycles.

Reset
REQ-031 RST_N low SHALL immediately force: state GET, depth 0, RESULT 0, ERR_CODE 0, RESULT_STB 0, all ACKs 0, BUSY 0.
REQ-032 Reset mid-expression SHALL discard partial stack; first accepted token after RST_N rises starts a new expression.
REQ-033 Stack storage contents need not reset; only depth pointer.

Verification
REQ-034 Tokens 3,4,'+',2,'*',END -> RESULT 14, ERR_CODE 0, RESULT_STB until ACK.
REQ-035 Tokens 2,5,'-',END -> RESULT 0xFFFD (DATA_W=16); tokens 5,'-' -> ERR_CODE 1, stack cleared after ACK.
REQ-036 Tokens 8,0,'/' -> ERR_CODE 3; after RESULT_ACK, tokens 9,3,'/',END -> RESULT 3.
REQ-037 DEPTH=8, nine numbers -> 9th gives ERR_CODE 2, NUMBER_ACK pulse for it, no further ACKs until RESULT_ACK; SIGN_IN='%' -> ERR_CODE 4.
REQ-038 NUMBER_STB and SIGN_STB raised same cycle with stack [6] -> NUMBER_ACK first, SIGN_ACK at next GET; tokens 6,2 with '-' held -> RESULT 4 on END.
REQ-039 RST_N low after tokens 1,2 -> all outputs 0 at once; then 1,1,'+',END -> RESULT 2.

Source files
------------

// File: rtl/postfix_eval.sv
// postfix_eval: token-driven postfix (RPN) integer evaluator with an operand stack.
// Rev 1.0 -- initial release.
`default_nettype none

module postfix_eval #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_number_in,
  input  logic              i_number_stb,
  output logic              o_number_ack,
  input  logic [7:0]        i_sign_in,
  input  logic              i_sign_stb,
  output logic              o_sign_ack,
  input  logic              i_end_stb,
  output logic              o_end_ack,
  output logic [DATA_W-1:0] o_result,
  output logic [2:0]        o_err_code,
  output logic              o_result_stb,
  input  logic              i_result_ack,
  output logic              o_busy
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] C_FULL = PW'(DEPTH);
  localparam logic [2:0] C_ERR_UNDER = 3'd1;
  localparam logic [2:0] C_ERR_OVER  = 3'd2;
  localparam logic [2:0] C_ERR_DIV0  = 3'd3;
  localparam logic [2:0] C_ERR_OP    = 3'd4;
  localparam logic [2:0] C_ERR_END   = 3'd5;

  typedef enum logic [1:0] {S_GET = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_stack [DEPTH];
  logic [PW-1:0]     r_depth;
  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_err;
  logic [7:0]        r_op;
  logic              r_number_ack, r_sign_ack, r_end_ack;

  logic              w_take_num, w_take_sign, w_take_end, w_do_op, w_clear;
  logic              w_set_err;
  logic [2:0]        w_err_val;
  logic              w_push, w_sign_ok, w_ack_busy;
  logic [AW-1:0]     w_a_idx, w_b_idx, w_push_idx;
  logic [DATA_W-1:0] w_a, w_b, w_alu;

  assign w_push_idx = AW'(r_depth);
  assign w_b_idx    = AW'(r_depth - PW'(1));
  assign w_a_idx    = AW'(r_depth - PW'(2));
  assign w_a        = r_stack[w_a_idx];
  assign w_b        = r_stack[w_b_idx];
  assign w_sign_ok  = (i_sign_in == 8'd43) || (i_sign_in == 8'd45) ||
                      (i_sign_in == 8'd42) || (i_sign_in == 8'd47);
  // The ACK cycle blocks acceptance so a still-held strobe is not taken twice.
  assign w_ack_busy = r_number_ack | r_sign_ack | r_end_ack;
  assign w_push     = w_take_num && (r_depth != C_FULL);

  // Divide by -1 is negation, which wraps most-negative onto itself.
  always_comb begin
    w_alu = '0;
    case (r_op)
      8'd43:   w_alu = w_a + w_b;
      8'd45:   w_alu = w_a - w_b;
      8'd42:   w_alu = w_a * w_b;
      default: begin
        if (w_b == '1)      w_alu = '0 - w_a;
        else if (w_b != '0) w_alu = DATA_W'($signed(w_a) / $signed(w_b));
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_GET;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take_num  = 1'b0;
    w_take_sign = 1'b0;
    w_take_end  = 1'b0;
    w_do_op     = 1'b0;
    w_clear     = 1'b0;
    w_set_err   = 1'b0;
    w_err_val   = '0;
    case (r_state)
      S_GET: begin
        if (!w_ack_busy) begin
          if (i_number_stb) begin
            w_take_num = 1'b1;
            if (r_depth == C_FULL) begin
              w_set_err   = 1'b1;
              w_err_val   = C_ERR_OVER;
              w_state_nxt = S_DONE;
            end
          end else if (i_sign_stb) begin
            w_take_sign = 1'b1;
            if (w_sign_ok) begin
              w_state_nxt = S_EXEC;
            end else begin
              w_set_err   = 1'b1;
              w_err_val   = C_ERR_OP;
              w_state_nxt = S_DONE;
            end
          end else if (i_end_stb) begin
            w_take_end  = 1'b1;
            w_state_nxt = S_DONE;
            if (r_depth != PW'(1)) begin
              w_set_err = 1'b1;
              w_err_val = C_ERR_END;
            end
          end
        end
      end
      S_EXEC: begin
        w_state_nxt = S_GET;
        if (r_depth < PW'(2)) begin
          w_set_err   = 1'b1;
          w_err_val   = C_ERR_UNDER;
          w_state_nxt = S_DONE;
        end else if ((r_op == 8'd47) && (w_b == '0)) begin
          w_set_err   = 1'b1;
          w_err_val   = C_ERR_DIV0;
          w_state_nxt = S_DONE;
        end else begin
          w_do_op = 1'b1;
        end
      end
      S_DONE: begin
        if (i_result_ack) begin
          w_clear     = 1'b1;
          w_state_nxt = S_GET;
        end
      end
      default: w_state_nxt = S_GET;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth      <= '0;
      r_result     <= '0;
      r_err        <= '0;
      r_op         <= '0;
      r_number_ack <= 1'b0;
      r_sign_ack   <= 1'b0;
      r_end_ack    <= 1'b0;
    end else begin
      r_number_ack <= w_take_num;
      r_sign_ack   <= w_take_sign;
      r_end_ack    <= w_take_end;
      if (w_take_sign) r_op <= i_sign_in;
      if (w_clear) begin
        r_depth  <= '0;
        r_result <= '0;
        r_err    <= '0;
      end else begin
        if (w_set_err) begin
          r_err    <= w_err_val;
          r_result <= '0;
        end
        if (w_push)                              r_depth  <= r_depth + PW'(1);
        if (w_do_op)                             r_depth  <= r_depth - PW'(1);
        if (w_take_end && (r_depth == PW'(1)))   r_result <= w_b;
      end
    end
  end

  // Stack storage needs no reset; the depth pointer alone defines validity.
  always_ff @(posedge i_clk) begin
    if (w_push)       r_stack[w_push_idx] <= DATA_W'(i_number_in);
    else if (w_do_op) r_stack[w_a_idx]    <= w_alu;
  end

  assign o_number_ack = r_number_ack;
  assign o_sign_ack   = r_sign_ack;
  assign o_end_ack    = r_end_ack;
  assign o_result     = r_result;
  assign o_err_code   = r_err;
  assign o_result_stb = (r_state == S_DONE);
  assign o_busy       = (r_state != S_GET);

endmodule

`default_nettype wire

// File: tb/tb_postfix_eval.sv
// tb_postfix_eval: directed scoreboard bench for postfix_eval (DATA_W=16, DEPTH=8).
// Rev 1.0 -- initial release.
`default_nettype none

module tb_postfix_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  number_in = '0;
  logic        number_stb = 1'b0;
  logic        number_ack;
  logic [7:0]  sign_in = '0;
  logic        sign_stb = 1'b0;
  logic        sign_ack;
  logic        end_stb = 1'b0;
  logic        end_ack;
  logic [15:0] result;
  logic [2:0]  err_code;
  logic        result_stb;
  logic        result_ack = 1'b0;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [18:0] exp_q [$];

  postfix_eval #(.DATA_W(16), .DEPTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_number_in(number_in), .i_number_stb(number_stb), .o_number_ack(number_ack),
    .i_sign_in(sign_in), .i_sign_stb(sign_stb), .o_sign_ack(sign_ack),
    .i_end_stb(end_stb), .o_end_ack(end_ack),
    .o_result(result), .o_err_code(err_code), .o_result_stb(result_stb),
    .i_result_ack(result_ack), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_num(input logic [7:0] v);
    int t;
    @(negedge clk);
    number_in  = v;
    number_stb = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!number_ack && t < 20);
    chk("number_ack", 32'(number_ack), 32'd1);
    number_stb = 1'b0;
  endtask

  task automatic send_sign(input logic [7:0] c);
    int t;
    @(negedge clk);
    sign_in  = c;
    sign_stb = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!sign_ack && t < 20);
    chk("sign_ack", 32'(sign_ack), 32'd1);
    sign_stb = 1'b0;
  endtask

  task automatic send_end();
    int t;
    @(negedge clk);
    end_stb = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!end_ack && t < 20);
    chk("end_ack", 32'(end_ack), 32'd1);
    end_stb = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int t;
    logic [18:0] e;
    t = 0;
    while (!result_stb && t < 20) begin @(negedge clk); t++; end
    chk({tag, "_stb"}, 32'(result_stb), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
    chk({tag, "_result"}, 32'(result), 32'(e[18:3]));
    chk({tag, "_err"}, 32'(err_code), 32'(e[2:0]));
    @(negedge clk);
    chk({tag, "_stb_held"}, 32'(result_stb), 32'd1);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk({tag, "_stb_drop"}, {30'd0, result_stb, busy}, 32'd0);
  endtask

  initial begin
    int acks;
    int t;
    // Reset state
    #12;
    chk("reset_outputs", {7'd0, result, err_code, result_stb, busy, number_ack, sign_ack, end_ack},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3 4 + 2 * -> 14, with the operator's EXEC cycle visible as busy
    send_num(8'd3);
    send_num(8'd4);
    @(negedge clk);
    sign_in = 8'd43;
    sign_stb = 1'b1;
    @(negedge clk);
    chk("op_exec_busy", {30'd0, sign_ack, busy}, 32'd3);
    sign_stb = 1'b0;
    @(negedge clk);
    chk("op_back_get", {30'd0, sign_ack, busy}, 32'd0);
    send_num(8'd2);
    send_sign(8'd42);
    send_end();
    exp_q.push_back({16'd14, 3'd0});
    get_result("mul_add");

    // 2 5 - -> -3 wraps
    send_num(8'd2);
    send_num(8'd5);
    send_sign(8'd45);
    send_end();
    exp_q.push_back({16'hFFFD, 3'd0});
    get_result("sub_wrap");

    // 5 - -> underflow; then stack must be empty: 7 END -> 7
    send_num(8'd5);
    send_sign(8'd45);
    exp_q.push_back({16'd0, 3'd1});
    get_result("underflow");
    send_num(8'd7);
    send_end();
    exp_q.push_back({16'd7, 3'd0});
    get_result("after_underflow");

    // 8 0 / -> divide by zero; then 9 3 / -> 3
    send_num(8'd8);
    send_num(8'd0);
    send_sign(8'd47);
    exp_q.push_back({16'd0, 3'd3});
    get_result("div_zero");
    send_num(8'd9);
    send_num(8'd3);
    send_sign(8'd47);
    send_end();
    exp_q.push_back({16'd3, 3'd0});
    get_result("div_ok");

    // Nine numbers overflow DEPTH=8; held strobe must go unacknowledged
    for (int i = 1; i <= 9; i++) send_num(8'(i));
    exp_q.push_back({16'd0, 3'd2});
    @(negedge clk);
    number_in = 8'd10;
    number_stb = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (number_ack) acks++;
    end
    chk("no_ack_in_done", 32'(acks), 32'd0);
    number_stb = 1'b0;
    get_result("overflow");

    // Bad operator
    send_sign(8'd37);
    exp_q.push_back({16'd0, 3'd4});
    get_result("bad_op");

    // Number and sign raised together with stack [6]: number wins
    send_num(8'd6);
    @(negedge clk);
    number_in = 8'd2;
    number_stb = 1'b1;
    sign_in = 8'd45;
    sign_stb = 1'b1;
    @(negedge clk);
    chk("prio_num_first", {30'd0, number_ack, sign_ack}, 32'd2);
    number_stb = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!sign_ack && t < 20);
    chk("prio_sign_later", {30'd0, number_ack, sign_ack}, 32'd1);
    sign_stb = 1'b0;
    send_end();
    exp_q.push_back({16'd4, 3'd0});
    get_result("priority");

    // Signed truncating division: (0-7)/2 -> -3
    send_num(8'd0);
    send_num(8'd7);
    send_sign(8'd45);
    send_num(8'd2);
    send_sign(8'd47);
    send_end();
    exp_q.push_back({16'hFFFD, 3'd0});
    get_result("div_trunc");

    // Most-negative / -1 wraps: 128*128*2 = 0x8000; (0-1) = -1
    send_num(8'd128);
    send_num(8'd128);
    send_sign(8'd42);
    send_num(8'd2);
    send_sign(8'd42);
    send_num(8'd0);
    send_num(8'd1);
    send_sign(8'd45);
    send_sign(8'd47);
    send_end();
    exp_q.push_back({16'h8000, 3'd0});
    get_result("div_minneg");

    // END with two entries -> bad end
    send_num(8'd1);
    send_num(8'd2);
    send_end();
    exp_q.push_back({16'd0, 3'd5});
    get_result("bad_end");

    // Asynchronous reset while holding a result, mid-cycle
    send_num(8'd1);
    send_num(8'd2);
    send_end();
    t = 0;
    while (!result_stb && t < 20) begin @(negedge clk); t++; end
    chk("pre_reset_stb", {29'd0, err_code}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {7'd0, result, err_code, result_stb, busy, number_ack, sign_ack, end_ack},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_num(8'd1);
    send_num(8'd1);
    send_sign(8'd43);
    send_end();
    exp_q.push_back({16'd2, 3'd0});
    get_result("after_reset");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
